sel_mux_top: RTL and testbench

- Registered two-stage bit selector.
- Stage 1 picks one of four data bits (A..D) with SEL1.
- Stage 2 combines that bit with A, B or its inverse under SEL2.
- The result is registered to out_nume. It is a leaf block used as a configurable single-bit routing/logic cell.

---
 rtl/sel_mux_top.sv | 117 +++++++++++
 tb/tb_sel_mux_top.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sel_mux_top.sv
// -----------------------------------------------------------------------------
// sel_mux_top
//
// Purpose:
//   Registered two-stage single-bit selector, used as a configurable routing or
//   logic cell.
//     Stage 1 (m1) picks one of the data bits A/B/C/D using SEL1.
//     Stage 2 (m2) turns m1 into one of: m1, ~m1, m1 | A, m1 ^ B (SEL2).
//   m2 is captured into the output flop on every rising clock edge. There is
//   no enable.
//
// Optional feature (macro SEL_MUX_TOP_INPUT_SYNC_EN):
//   When the macro is defined, A..D each pass through a 2-flop synchronizer
//   before they reach stage 1 and stage 2. The data-to-output latency then
//   becomes 3 cycles. SEL1 and SEL2 are treated as quasi-static configuration
//   and are not synchronized, so the select-to-output latency stays 1 cycle.
//   When the macro is undefined, every input reaches out_nume after 1 cycle.
//
// Parameters:
//   RST_VAL   value loaded into out_nume and into every internal flop on reset
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous, active-low reset
//   A         in   1  data bit 0; also the OR operand of stage-2 mode 2
//   B         in   1  data bit 1; also the XOR operand of stage-2 mode 3
//   C         in   1  data bit 2
//   D         in   1  data bit 3
//   SEL1      in   2  stage-1 select (0:A 1:B 2:C 3:D)
//   SEL2      in   2  stage-2 operation (0:m1 1:~m1 2:m1|A 3:m1^B)
//   out_nume  out  1  registered result, driven directly by a flop
// -----------------------------------------------------------------------------
module sel_mux_top #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic [1:0] SEL1,
  input  logic [1:0] SEL2,
  output logic       out_nume
);

  // Data bits as seen by the selection logic, packed {D, C, B, A}.
  logic [3:0] w_data;

`ifdef SEL_MUX_TOP_INPUT_SYNC_EN
  // Two-flop synchronizer per data bit. Each bit gets its own pair of flops so
  // that the tools can place every pair close to its input pin.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_raw;

  assign w_raw = {D, C, B, A};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1[gi] <= RST_VAL;
        r_sync2[gi] <= RST_VAL;
      end else begin
        r_sync1[gi] <= w_raw[gi];
        r_sync2[gi] <= r_sync1[gi];
      end
    end
  end

  assign w_data = r_sync2;
`else
  assign w_data = {D, C, B, A};
`endif

  logic w_m1;
  logic w_m2;
  logic r_out;

  // Stage 1: a plain 4:1 mux. All four codes are decoded, so no latch is
  // possible.
  always_comb begin
    w_m1 = w_data[0];
    case (SEL1)
      2'd0: w_m1 = w_data[0];
      2'd1: w_m1 = w_data[1];
      2'd2: w_m1 = w_data[2];
      2'd3: w_m1 = w_data[3];
      default: w_m1 = w_data[0];
    endcase
  end

  // Stage 2: the operands A and B are taken from the same (possibly
  // synchronized) data path as stage 1. Without that, the two stages could see
  // the same input at different times.
  always_comb begin
    w_m2 = w_m1;
    case (SEL2)
      2'd0: w_m2 = w_m1;
      2'd1: w_m2 = ~w_m1;
      2'd2: w_m2 = w_m1 | w_data[0];
      2'd3: w_m2 = w_m1 ^ w_data[1];
      default: w_m2 = w_m1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= RST_VAL;
    end else begin
      r_out <= w_m2;
    end
  end

  assign out_nume = r_out;

endmodule

// File: tb/tb_sel_mux_top.sv
// -----------------------------------------------------------------------------
// tb_sel_mux_top
//
// Self-checking bench for sel_mux_top. It applies directed, exhaustive and
// randomized stimulus. A behavioural model kept in the bench predicts the
// registered output: it indexes the data word with SEL1, applies the SEL2
// operation arithmetically, and uses a short history of the data inputs to
// account for the data latency.
// Build with +define+SEL_MUX_TOP_INPUT_SYNC_EN to also check the synchronized
// variant of the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sel_mux_top;

  logic       clk;
  logic       rst_n;
  logic       A, B, C, D;
  logic [1:0] SEL1, SEL2;
  logic       out_nume;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEL_MUX_TOP_INPUT_SYNC_EN
  localparam int LAT_D = 3;
`else
  localparam int LAT_D = 1;
`endif

  // hist[0] holds the data sampled at the latest edge; hist[k] holds the data
  // sampled k edges earlier. Reset fills the history with RST_VAL (0).
  logic [3:0] hist [0:2];

  sel_mux_top #(.RST_VAL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .SEL1     (SEL1),
    .SEL2     (SEL2),
    .out_nume (out_nume)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: out_nume=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. dat is packed {D,C,B,A}.
  function automatic logic model(input logic [3:0] dat, input int s1, input int s2);
    logic m1;
    m1 = dat[s1];
    case (s2)
      0:       return m1;
      1:       return !m1;
      2:       return m1 || dat[0];
      default: return m1 != dat[1];
    endcase
  endfunction

  function automatic void clear_hist();
    for (int k = 0; k < 3; k++) hist[k] = 4'b0000;
  endfunction

  // Drive the inputs on the falling edge and let the next rising edge capture
  // them. Then advance the model and compare 1 ns after that edge.
  // Returns the expected value so that callers can also compare it with
  // hand-computed constants.
  task automatic step(input string tag, input logic [3:0] dat, input int s1,
                      input int s2, output logic exp);
    @(negedge clk);
    {D, C, B, A} = dat;
    SEL1 = 2'(s1);
    SEL2 = 2'(s2);
    @(posedge clk);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = dat;
    exp = model(hist[LAT_D-1], s1, s2);
    check_bit(tag, out_nume, exp);
    $display("txn %-8s dat(DCBA)=%b sel1=%0d sel2=%0d out=%b exp=%b",
             tag, dat, s1, s2, out_nume, exp);
  endtask

  // Hold one setting for LAT_D cycles, so that the final output depends only
  // on this setting. Then also compare it with a value worked out by hand.
  task automatic settle(input string tag, input logic [3:0] dat, input int s1,
                        input int s2, input logic want);
    logic e;
    for (int k = 0; k < LAT_D; k++) step(tag, dat, s1, s2, e);
    check_bit({tag, "_const"}, out_nume, want);
  endtask

  initial begin
    logic e;
    logic [3:0] r_dat;
    rst_n = 1'b0;
    {D, C, B, A} = 4'b0001;
    SEL1 = 2'd0;
    SEL2 = 2'd0;
    clear_hist();

    // Reset held while A=1 selected: output stays 0 on every edge.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_bit("rst_hold", out_nume, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Get the output to 1, then assert reset between edges.
    settle("pre_arst", 4'b0001, 0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_rst", out_nume, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();

    // SEL1 sweep with D,C,B,A = 1,1,0,1 (A=1,B=0,C=1,D=1).
    settle("sweep0", 4'b1101, 0, 0, 1'b1);
    settle("sweep1", 4'b1101, 1, 0, 1'b0);
    settle("sweep2", 4'b1101, 2, 0, 1'b1);
    settle("sweep3", 4'b1101, 3, 0, 1'b1);

    // Directed case with OR and XOR operations.
    settle("dir_or1", 4'b0001, 2, 2, 1'b1);
    settle("dir_or0", 4'b0000, 2, 2, 1'b0);
    settle("dir_orB", 4'b0000, 1, 2, 1'b0);
    settle("dir_xor", 4'b0000, 0, 3, 1'b0);

    // Inversion and XOR with A=0,B=1,C=1,D=0.
    settle("inv_c",   4'b0110, 2, 1, 1'b0);
    settle("inv_d",   4'b0110, 3, 1, 1'b1);
    settle("xor_c",   4'b0110, 2, 3, 1'b0);
    settle("xor_d",   4'b0110, 3, 3, 1'b1);

`ifdef SEL_MUX_TOP_INPUT_SYNC_EN
    // Data latency of 3 edges, select latency of 1 edge.
    settle("sync_pre", 4'b0000, 3, 0, 1'b0);
    step("sync_d1", 4'b1000, 3, 0, e);
    check_bit("sync_d1c", out_nume, 1'b0);
    step("sync_d2", 4'b1000, 3, 0, e);
    check_bit("sync_d2c", out_nume, 1'b0);
    step("sync_d3", 4'b1000, 3, 0, e);
    check_bit("sync_d3c", out_nume, 1'b1);
    step("sync_sel", 4'b1000, 0, 0, e);
    check_bit("sync_selc", out_nume, 1'b0);
`endif

    // Exhaustive: every combination of {A,B,C,D,SEL1,SEL2}.
    for (int i = 0; i < 256; i++) begin
      r_dat = {i[4], i[5], i[6], i[7]};  // i[7]=A ... i[4]=D
      step("exh", r_dat, (i >> 2) & 3, i & 3, e);
    end

    // Random stimulus.
    for (int i = 0; i < 200; i++) begin
      step("rand", 4'($urandom_range(0, 15)), $urandom_range(0, 3),
           $urandom_range(0, 3), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
